// File: rtl/vospi_pkg.sv
// Shared VoSPI constants and the frame parser state type.
package vospi_pkg;

   localparam int         VOSPI_PAYLOAD_BYTES  = 160;
   localparam int         VOSPI_HEADER_BYTES   = 4;
   localparam int         VOSPI_LINES          = 60;
   localparam logic [3:0] VOSPI_DISCARD_NIBBLE = 4'hF;

   // HDR waits for a packet header, PAYLOAD forwards pixels, DROP swallows a packet.
   typedef enum logic [1:0] {
      HDR     = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } vospi_state_t;

endpackage

// File: rtl/vospi_frame_parser_if.sv
// Generic AXI-Stream bundle used for both the raw word input and the pixel output.
interface vospi_frame_parser_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic              tuser;

   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/vospi_pixel_unpacker.sv
// Splits a 32-bit payload word into two big-endian 16-bit pixels held in a
// two-entry register, and presents them one per cycle on the pixel stream.
module vospi_pixel_unpacker (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [31:0]                 word_data,
   input  logic                        word_valid,
   input  logic                        word_sof,
   input  logic                        word_last,
   input  logic                        word_eof,
   output logic                        word_ready,
   output logic                        frame_end,
   vospi_frame_parser_if.master        m_axis
);
   // fill_reg: 2 = both pixels pending (pixA next), 1 = only pixB pending, 0 = empty
   logic [1:0]  fill_reg;
   logic [15:0] pix_a_reg;
   logic [15:0] pix_b_reg;
   logic        sof_a_reg;
   logic        last_b_reg;
   logic        eof_b_reg;
   logic        pix_hs;
   logic        load;

   assign pix_hs     = m_axis.tvalid && m_axis.tready;
   // Accept a new word when empty, or when the last pending pixel leaves this cycle.
   assign word_ready = (fill_reg == 2'd0) || ((fill_reg == 2'd1) && m_axis.tready);
   assign load       = word_valid && word_ready;

   assign m_axis.tvalid = (fill_reg != 2'd0);
   assign m_axis.tdata  = (fill_reg == 2'd2) ? pix_a_reg : pix_b_reg;
   assign m_axis.tuser  = (fill_reg == 2'd2) && sof_a_reg;
   assign m_axis.tlast  = (fill_reg == 2'd1) && last_b_reg;
   assign frame_end     = pix_hs && (fill_reg == 2'd1) && eof_b_reg;

   // Holding register: load a fresh word, otherwise retire one pixel per handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_reg   <= 2'd0;
         pix_a_reg  <= 16'd0;
         pix_b_reg  <= 16'd0;
         sof_a_reg  <= 1'b0;
         last_b_reg <= 1'b0;
         eof_b_reg  <= 1'b0;
      end else if (load) begin
         fill_reg   <= 2'd2;
         pix_a_reg  <= {word_data[7:0], word_data[15:8]};
         pix_b_reg  <= {word_data[23:16], word_data[31:24]};
         sof_a_reg  <= word_sof;
         last_b_reg <= word_last;
         eof_b_reg  <= word_eof;
      end else if (pix_hs) begin
         fill_reg   <= fill_reg - 2'd1;
      end
   end

endmodule

// File: rtl/vospi_frame_parser.sv
// VoSPI packet parser: decodes headers, drops discard packets, tracks the
// line sequence and forwards payload pixels with frame/line markers.
module vospi_frame_parser
   import vospi_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int LINE_PIXELS    = VOSPI_PAYLOAD_BYTES / 2,
   parameter int FRAME_LINES    = VOSPI_LINES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vospi_frame_parser_if.slave  s_axis,
   vospi_frame_parser_if.master m_axis,
   output logic                 frame_done,
   output logic                 sync_err,
   output logic [5:0]           line_num
);
   localparam int         WORDS_PER_LINE = (LINE_PIXELS * 2) / (AXI_DATA_WIDTH / 8);
   localparam logic [5:0] LAST_WORD      = 6'(WORDS_PER_LINE - 1);
   localparam logic [5:0] LAST_LINE      = 6'(FRAME_LINES - 1);

   vospi_state_t state_reg, state_next;
   logic [5:0]   word_cnt_reg, word_cnt_next;
   logic [5:0]   expected_reg, expected_next;
   logic [5:0]   line_reg, line_next;
   logic         ready_en_reg;

   logic [7:0]   hdr_b0;
   logic [7:0]   hdr_b1;
   logic [11:0]  hdr_id;
   logic         hdr_discard;
   logic         unp_ready;
   logic         word_hs;
   logic         last_word;
   logic         unused_sideband;

   assign hdr_b0      = s_axis.tdata[7:0];
   assign hdr_b1      = s_axis.tdata[15:8];
   assign hdr_id      = {hdr_b0[3:0], hdr_b1};
   assign hdr_discard = (hdr_b0[3:0] == VOSPI_DISCARD_NIBBLE);

   assign s_axis.tready = ready_en_reg && ((state_reg != PAYLOAD) || unp_ready);
   assign word_hs       = s_axis.tvalid && s_axis.tready;
   assign last_word     = (word_cnt_reg == LAST_WORD);
   assign line_num      = line_reg;
   // Packet framing is purely by word count, so input sideband bits are ignored.
   assign unused_sideband = s_axis.tlast ^ s_axis.tuser;

   // State, counters and the one-cycle input hold-off after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= HDR;
         word_cnt_reg <= 6'd0;
         expected_reg <= 6'd0;
         line_reg     <= 6'd0;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         word_cnt_reg <= word_cnt_next;
         expected_reg <= expected_next;
         line_reg     <= line_next;
         ready_en_reg <= 1'b1;
      end
   end

   // Header decode and sequence tracking. The expected line advances when the
   // last payload word is accepted so the next header, which may arrive while
   // the final pixels still drain, is compared against the following line.
   always_comb begin
      state_next    = state_reg;
      word_cnt_next = word_cnt_reg;
      expected_next = expected_reg;
      line_next     = line_reg;
      sync_err      = 1'b0;
      case (state_reg)
         HDR: begin
            if (word_hs) begin
               word_cnt_next = 6'd0;
               if (hdr_discard) begin
                  state_next = DROP;
               end else if (hdr_id == {6'd0, expected_reg}) begin
                  state_next = PAYLOAD;
                  line_next  = expected_reg;
               end else if (hdr_id == 12'd0) begin
                  sync_err   = 1'b1;
                  state_next = PAYLOAD;
                  line_next  = 6'd0;
               end else begin
                  sync_err      = 1'b1;
                  expected_next = 6'd0;
                  state_next    = DROP;
               end
            end
         end
         PAYLOAD: begin
            if (word_hs) begin
               if (last_word) begin
                  state_next    = HDR;
                  expected_next = (line_reg == LAST_LINE) ? 6'd0 : line_reg + 6'd1;
               end else begin
                  word_cnt_next = word_cnt_reg + 6'd1;
               end
            end
         end
         DROP: begin
            if (word_hs) begin
               if (last_word) begin
                  state_next = HDR;
               end else begin
                  word_cnt_next = word_cnt_reg + 6'd1;
               end
            end
         end
         default: state_next = HDR;
      endcase
   end

   vospi_pixel_unpacker u_unpacker (
      .clk        (clk),
      .rst_n      (rst_n),
      .word_data  (s_axis.tdata[31:0]),
      .word_valid (ready_en_reg && (state_reg == PAYLOAD) && s_axis.tvalid),
      .word_sof   ((word_cnt_reg == 6'd0) && (line_reg == 6'd0)),
      .word_last  (last_word),
      .word_eof   (last_word && (line_reg == LAST_LINE)),
      .word_ready (unp_ready),
      .frame_end  (frame_done),
      .m_axis     (m_axis)
   );

endmodule

// File: tb/tb_vospi_frame_parser.sv
// Bench for vospi_frame_parser: packets are built at packet level, a
// packet-level model predicts the pixel stream and pulse counts, and a
// monitor collects what the DUT emits.
module tb_vospi_frame_parser;

   localparam int LP = 80;
   localparam int FL = 60;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
      logic        u;
   } pix_t;

   typedef struct {
      logic [31:0] data;
      bit          tag;
   } wrd_t;

   logic       clk;
   logic       rst_n;
   logic       frame_done;
   logic       sync_err;
   logic [5:0] line_num;

   vospi_frame_parser_if #(.DATA_W(32)) s_if ();
   vospi_frame_parser_if #(.DATA_W(16)) m_if ();

   vospi_frame_parser #(
      .AXI_DATA_WIDTH (32),
      .LINE_PIXELS    (LP),
      .FRAME_LINES    (FL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .line_num   (line_num)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   wrd_t word_q[$];
   pix_t exp_q[$];
   pix_t got_q[$];
   int   m_exp = 0;
   int   exp_se = 0;
   int   exp_fd = 0;
   int   se_cnt = 0;
   int   fd_cnt = 0;
   int   stall_viol = 0;
   int   ready_viol = 0;
   int   cyc = 0;
   int   first_hs = -1;
   int   last_hs = -1;
   bit   bp_en = 0;
   bit   cur_tag = 0;
   bit   prev_stall = 0;
   bit   prev_mid_hs = 0;
   pix_t prev_pix;

   // Downstream ready: always high, or about 30% low when backpressure is on.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Monitor: collects pixels, counts pulses and protocol violations.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            got_q.push_back({m_if.tdata, m_if.tlast, m_if.tuser});
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         if (prev_stall && (m_if.tvalid !== 1'b1 || {m_if.tdata, m_if.tlast, m_if.tuser} !== prev_pix))
            stall_viol++;
         prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
         prev_pix   = {m_if.tdata, m_if.tlast, m_if.tuser};
         if (prev_mid_hs && s_if.tready !== 1'b0) ready_viol++;
         prev_mid_hs = cur_tag && (s_if.tvalid === 1'b1) && (s_if.tready === 1'b1);
         if (frame_done === 1'b1) fd_cnt++;
         if (sync_err === 1'b1) se_cnt++;
      end
   end

   // Packet-level reference: queue the 41 words of one packet and predict
   // which pixels appear, following the header rules line by line.
   task automatic add_packet(input logic [7:0] b0, input logic [7:0] b1, input bit rnd);
      logic [11:0] id;
      logic [15:0] p[LP];
      bit          emit;
      int          line;
      wrd_t        w;
      pix_t        e;
      id   = {b0[3:0], b1};
      emit = 0;
      line = 0;
      if (b0[3:0] == 4'hF) begin
         emit = 0;
      end else if (int'(id) == m_exp) begin
         emit = 1;
         line = m_exp;
      end else if (id == 12'd0) begin
         exp_se++;
         emit = 1;
         line = 0;
      end else begin
         exp_se++;
         m_exp = 0;
      end
      for (int n = 0; n < LP; n++) p[n] = rnd ? 16'($urandom) : 16'(int'(id) * LP + n);
      w.data = {16'($urandom), b1, b0};
      w.tag  = 0;
      word_q.push_back(w);
      for (int k = 0; k < LP / 2; k++) begin
         w.data = {p[2*k+1][7:0], p[2*k+1][15:8], p[2*k][7:0], p[2*k][15:8]};
         w.tag  = emit && (k != LP / 2 - 1);
         word_q.push_back(w);
      end
      if (emit) begin
         for (int n = 0; n < LP; n++) begin
            e.d = p[n];
            e.l = (n == LP - 1);
            e.u = (line == 0) && (n == 0);
            exp_q.push_back(e);
         end
         m_exp = (line == FL - 1) ? 0 : line + 1;
         if (line == FL - 1) exp_fd++;
      end
      $display("pkt id=%03h emit=%0d line=%0d", id, emit, line);
   endtask

   task automatic add_lines(input int first, input int last, input bit rnd);
      for (int i = first; i <= last; i++) add_packet({4'h0, 4'(i >> 8)}, 8'(i), rnd);
   endtask

   // Present queued words back to back; a word stuck too long ends the stream.
   task automatic drive_words();
      int wait_cyc;
      wait_cyc = 0;
      while (word_q.size() > 0) begin
         s_if.tdata  = word_q[0].data;
         s_if.tvalid = 1'b1;
         cur_tag     = word_q[0].tag;
         @(negedge clk);
         if (s_if.tready === 1'b1) begin
            void'(word_q.pop_front());
            wait_cyc = 0;
         end else begin
            wait_cyc++;
            if (wait_cyc > 500) begin
               checks++;
               errors++;
               $display("FAIL drive_timeout: word stalled %0d cycles, required acceptance", wait_cyc);
               word_q.delete();
            end
         end
         @(posedge clk);
         #1;
      end
      s_if.tvalid = 1'b0;
      cur_tag     = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 5000) begin
         @(posedge clk);
         n++;
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      word_q.delete();
      exp_q.delete();
      got_q.delete();
      m_exp = 0; exp_se = 0; exp_fd = 0;
      se_cnt = 0; fd_cnt = 0; stall_viol = 0; ready_viol = 0;
      first_hs = -1; last_hs = -1;
      prev_stall = 0; prev_mid_hs = 0;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      s_if.tvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_if.tvalid, s_if.tready, frame_done, sync_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: tvalid/tready/done/err=%b required 0000",
                  {m_if.tvalid, s_if.tready, frame_done, sync_err});
      end
      checks++;
      if ({m_if.tdata, m_if.tlast, m_if.tuser} !== 18'd0) begin
         errors++;
         $display("FAIL reset_pix: data/last/user=%h required 0", {m_if.tdata, m_if.tlast, m_if.tuser});
      end
      checks++;
      if (line_num !== 6'd0) begin
         errors++;
         $display("FAIL reset_line: line_num=%0d required 0", line_num);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (s_if.tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_holdoff: tready=%b first cycle after release, required 0", s_if.tready);
      end
      @(negedge clk);
      checks++;
      if (s_if.tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_hdr_ready: tready=%b in header state, required 1", s_if.tready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_frame();
      int mism, bad;
      do_reset();
      add_lines(0, FL - 1, 0);
      drive_words();
      wait_drain();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL clean_len: got %0d pixels, required %0d", got_q.size(), exp_q.size());
      end
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL clean_data: %0d bad pixels, first #%0d got %h required %h", mism, bad, got_q[bad], exp_q[bad]);
      end
      checks++;
      if (fd_cnt != 1 || se_cnt != 0) begin
         errors++;
         $display("FAIL clean_pulses: frame_done=%0d sync_err=%0d required 1 and 0", fd_cnt, se_cnt);
      end
      checks++;
      if (last_hs - first_hs + 1 != FL * LP) begin
         errors++;
         $display("FAIL clean_rate: %0d cycles for pixels, required %0d", last_hs - first_hs + 1, FL * LP);
      end
      checks++;
      if (ready_viol != 0) begin
         errors++;
         $display("FAIL clean_full_ready: %0d cycles ready while holding full, required 0", ready_viol);
      end
   endtask

   task automatic test_discard();
      int mism, bad;
      do_reset();
      add_lines(0, 10, 0);
      for (int i = 0; i < 3; i++) add_packet(8'h0F, 8'hFF, 1);
      add_packet(8'hAF, 8'h12, 1);
      add_lines(11, FL - 1, 0);
      drive_words();
      wait_drain();
      checks++;
      if (got_q.size() != FL * LP) begin
         errors++;
         $display("FAIL discard_len: got %0d pixels, required %0d", got_q.size(), FL * LP);
      end
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL discard_data: %0d bad pixels, first #%0d got %h required %h", mism, bad, got_q[bad], exp_q[bad]);
      end
      checks++;
      if (fd_cnt != 1 || se_cnt != 0) begin
         errors++;
         $display("FAIL discard_pulses: frame_done=%0d sync_err=%0d required 1 and 0", fd_cnt, se_cnt);
      end
   endtask

   task automatic test_seq_break();
      int mism, bad;
      do_reset();
      add_lines(0, 4, 1);
      add_packet(8'h00, 8'h07, 1);
      drive_words();
      wait_drain();
      checks++;
      if (se_cnt != 1) begin
         errors++;
         $display("FAIL seqbrk_first_err: sync_err pulses=%0d required 1", se_cnt);
      end
      // 0x005 is not the expected line 0 either, so it is dropped with its own pulse.
      add_packet(8'h00, 8'h05, 1);
      add_lines(0, 2, 1);
      drive_words();
      wait_drain();
      checks++;
      if (se_cnt != exp_se) begin
         errors++;
         $display("FAIL seqbrk_err_total: sync_err pulses=%0d required %0d", se_cnt, exp_se);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL seqbrk_len: got %0d pixels, required %0d", got_q.size(), exp_q.size());
      end
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL seqbrk_data: %0d bad pixels, first #%0d got %h required %h", mism, bad, got_q[bad], exp_q[bad]);
      end
   endtask

   task automatic test_backpressure();
      int mism, bad;
      do_reset();
      bp_en = 1;
      add_lines(0, FL - 1, 1);
      drive_words();
      wait_drain();
      bp_en = 0;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_len: got %0d pixels, required %0d", got_q.size(), exp_q.size());
      end
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL bp_data: %0d bad pixels, first #%0d got %h required %h", mism, bad, got_q[bad], exp_q[bad]);
      end
      checks++;
      if (stall_viol != 0) begin
         errors++;
         $display("FAIL bp_stable: %0d stalled cycles changed output, required 0", stall_viol);
      end
      checks++;
      if (ready_viol != 0) begin
         errors++;
         $display("FAIL bp_full_ready: %0d cycles ready while holding full, required 0", ready_viol);
      end
      checks++;
      if (fd_cnt != 1) begin
         errors++;
         $display("FAIL bp_frame_done: pulses=%0d required 1", fd_cnt);
      end
   endtask

   task automatic test_early_restart();
      int mism, bad;
      do_reset();
      add_lines(0, 31, 1);
      drive_words();
      wait_drain();
      checks++;
      if (line_num !== 6'd31) begin
         errors++;
         $display("FAIL restart_pre_line: line_num=%0d required 31", line_num);
      end
      add_packet(8'h00, 8'h00, 1);
      drive_words();
      wait_drain();
      checks++;
      if (se_cnt != 1) begin
         errors++;
         $display("FAIL restart_err: sync_err pulses=%0d required 1", se_cnt);
      end
      checks++;
      if (line_num !== 6'd0) begin
         errors++;
         $display("FAIL restart_line: line_num=%0d required 0", line_num);
      end
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0 || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL restart_data: %0d bad of %0d pixels (required %0d), first #%0d",
                  mism, got_q.size(), exp_q.size(), bad);
      end
   endtask

   task automatic test_reset_mid();
      int mism, bad;
      do_reset();
      add_lines(0, 3, 1);
      // Keep line 3's header and words 0..17 only.
      repeat (LP / 2 - 18) void'(word_q.pop_back());
      // Word 17 is still in the holding register when reset hits: 34 pixels of line 3 survive.
      repeat (LP - 34) void'(exp_q.pop_back());
      drive_words();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_if.tvalid, s_if.tready, frame_done, sync_err, line_num} !== 10'd0) begin
         errors++;
         $display("FAIL midrst_outputs: valid/ready/done/err/line=%b required 0",
                  {m_if.tvalid, s_if.tready, frame_done, sync_err, line_num});
      end
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0 || got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL midrst_pre: %0d bad of %0d pixels (required %0d)", mism, got_q.size(), exp_q.size());
      end
      do_reset();
      add_lines(0, FL - 1, 0);
      drive_words();
      wait_drain();
      mism = 0; bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
      checks++;
      if (mism != 0 || got_q.size() != FL * LP) begin
         errors++;
         $display("FAIL midrst_frame: %0d bad of %0d pixels (required %0d)", mism, got_q.size(), FL * LP);
      end
      checks++;
      if (fd_cnt != 1 || se_cnt != 0) begin
         errors++;
         $display("FAIL midrst_pulses: frame_done=%0d sync_err=%0d required 1 and 0", fd_cnt, se_cnt);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      s_if.tdata  = 32'd0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      test_reset();
      test_clean_frame();
      test_discard();
      test_seq_break();
      test_backpressure();
      test_early_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
